// File: rtl/fofb_cc_tester_pkg.sv
// Shared constants, state encodings and helpers for the FOFB CC link tester.
package fofb_cc_tester_pkg;

   localparam logic [15:0] IdleWord = 16'h50BC;
   localparam logic [1:0]  IdleK    = 2'b01;
   localparam logic [15:0] SopWord  = 16'h5CFB;
   localparam logic [1:0]  SopK     = 2'b01;
   localparam logic [15:0] EopWord  = 16'hFDFE;
   localparam logic [1:0]  EopK     = 2'b11;
   localparam logic [1:0]  DataK    = 2'b00;

   localparam logic [15:0] CrcPoly  = 16'h1021;
   localparam logic [15:0] CrcInit  = 16'hFFFF;

   localparam int unsigned PayloadLen  = 7;
   localparam logic [2:0]  PayloadLast = 3'(PayloadLen - 1);

   typedef enum logic [2:0] {
      TxIdle,
      TxGap,
      TxSop,
      TxPayload,
      TxCrc,
      TxEop,
      TxDone
   } tx_state_e;

   typedef enum logic [1:0] {
      RxHunt,
      RxCapture,
      RxCheckCrc,
      RxCheckEop
   } rx_state_e;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fofb_cc_crc16.sv
// Combinational CRC-16-CCITT update over one 16-bit word, MSB first.
module fofb_cc_crc16
   import fofb_cc_tester_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [15:0] data,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data[i]) begin
            c = {c[14:0], 1'b0} ^ CrcPoly;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/fofb_cc_top_tester.sv
// FOFB CC link tester: timeframe generator, packet transmitter and packet checker.
module fofb_cc_top_tester
   import fofb_cc_tester_pkg::*;
#(
   parameter int unsigned TEST_DURATION = 3,
   parameter int unsigned TF_PERIOD     = 10072,
   parameter int unsigned TF_END        = 7500,
   parameter logic [15:0] NODE_ID       = 16'd4,
   parameter int unsigned TX_IDLE_NUM   = 6
) (
   input  logic        txusrclk2_i,
   input  logic        mgtreset_n_i,
   input  logic [15:0] rx_data_i,
   input  logic [1:0]  rx_charisk_i,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_charisk_o,
   output logic        fai_fa_block_start_o,
   output logic        fai_fa_data_valid_o,
   output logic [15:0] fai_fa_d_o,
   output logic        timeframe_start_o,
   output logic        timeframe_end_o,
   output logic [15:0] err_count_o,
   output logic [15:0] rx_count_o,
   output logic        test_done_o,
   output logic        test_pass_o
);

   // ---------------- timeframe generation ----------------
   logic        active_q;
   logic [31:0] tf_cnt_q, tf_number_q, end_cnt_q;
   logic        done_q;
   logic        tf_start, tf_end, done_next;

   assign tf_start  = active_q && (tf_cnt_q == 32'd0);
   assign tf_end    = active_q && (tf_cnt_q == TF_END);
   // The end pulse is accounted before a coincident start can launch a packet.
   assign done_next = done_q || (tf_end && (end_cnt_q == TEST_DURATION - 1));

   always_ff @(posedge txusrclk2_i) begin
      if (!mgtreset_n_i) begin
         active_q    <= 1'b0;
         tf_cnt_q    <= 32'd0;
         tf_number_q <= 32'd0;
         end_cnt_q   <= 32'd0;
         done_q      <= 1'b0;
      end else begin
         active_q <= 1'b1;
         if (active_q) begin
            if (tf_cnt_q == TF_PERIOD - 1) begin
               tf_cnt_q    <= 32'd0;
               tf_number_q <= tf_number_q + 32'd1;
            end else begin
               tf_cnt_q <= tf_cnt_q + 32'd1;
            end
         end
         if (tf_end && !done_q) end_cnt_q <= end_cnt_q + 32'd1;
         done_q <= done_next;
      end
   end

   // ---------------- transmitter ----------------
   tx_state_e   tx_state_q;
   logic [15:0] tx_data_q, tx_crc_q, tx_crc_next, payload_word;
   logic [1:0]  tx_k_q;
   logic [31:0] gap_cnt_q, frame_no_q;
   logic [2:0]  tx_idx_q, pl_sel;

   // Selects the payload word to be presented in the next cycle.
   always_comb begin
      pl_sel = (tx_state_q == TxPayload) ? tx_idx_q + 3'd1 : 3'd0;
      case (pl_sel)
         3'd0:    payload_word = NODE_ID;
         3'd1:    payload_word = frame_no_q[31:16];
         3'd2:    payload_word = frame_no_q[15:0];
         3'd3:    payload_word = ~frame_no_q[31:16];
         3'd4:    payload_word = ~frame_no_q[15:0];
         3'd5:    payload_word = tf_number_q[31:16];
         default: payload_word = tf_number_q[15:0];
      endcase
   end

   fofb_cc_crc16 u_tx_crc (
      .crc_in  (tx_crc_q),
      .data    (tx_data_q),
      .crc_out (tx_crc_next)
   );

   always_ff @(posedge txusrclk2_i) begin
      if (!mgtreset_n_i) begin
         tx_state_q <= TxIdle;
         tx_data_q  <= IdleWord;
         tx_k_q     <= IdleK;
         gap_cnt_q  <= 32'd0;
         tx_idx_q   <= 3'd0;
         frame_no_q <= 32'd0;
         tx_crc_q   <= CrcInit;
      end else begin
         unique case (tx_state_q)
            TxIdle: begin
               if (done_next) begin
                  tx_state_q <= TxDone;
               end else if (tf_start) begin
                  gap_cnt_q <= 32'd0;
                  if (TX_IDLE_NUM == 0) begin
                     tx_state_q <= TxSop;
                     tx_data_q  <= SopWord;
                     tx_k_q     <= SopK;
                  end else begin
                     tx_state_q <= TxGap;
                  end
               end
            end
            TxGap: begin
               if (gap_cnt_q == TX_IDLE_NUM - 1) begin
                  tx_state_q <= TxSop;
                  tx_data_q  <= SopWord;
                  tx_k_q     <= SopK;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 32'd1;
               end
            end
            TxSop: begin
               tx_state_q <= TxPayload;
               tx_idx_q   <= 3'd0;
               tx_data_q  <= payload_word;
               tx_k_q     <= DataK;
               tx_crc_q   <= CrcInit;
            end
            TxPayload: begin
               tx_crc_q <= tx_crc_next;
               if (tx_idx_q == PayloadLast) begin
                  tx_state_q <= TxCrc;
                  tx_data_q  <= tx_crc_next;
               end else begin
                  tx_idx_q  <= tx_idx_q + 3'd1;
                  tx_data_q <= payload_word;
               end
            end
            TxCrc: begin
               tx_state_q <= TxEop;
               tx_data_q  <= EopWord;
               tx_k_q     <= EopK;
            end
            TxEop: begin
               frame_no_q <= frame_no_q + 32'd1;
               tx_data_q  <= IdleWord;
               tx_k_q     <= IdleK;
               tx_state_q <= done_next ? TxDone : TxIdle;
            end
            TxDone: begin
               tx_data_q <= IdleWord;
               tx_k_q    <= IdleK;
            end
         endcase
      end
   end

   // ---------------- receiver ----------------
   rx_state_e   rx_state_q;
   logic [2:0]  rx_idx_q;
   logic [15:0] rx_crc_q, rx_crc_next, err_q, rxc_q, fa_d_q;
   logic        fa_valid_q, fa_bs_q;
   logic        is_sop, is_eop;

   assign is_sop = (rx_data_i == SopWord) && (rx_charisk_i == SopK);
   assign is_eop = (rx_data_i == EopWord) && (rx_charisk_i == EopK);

   fofb_cc_crc16 u_rx_crc (
      .crc_in  (rx_crc_q),
      .data    (rx_data_i),
      .crc_out (rx_crc_next)
   );

   always_ff @(posedge txusrclk2_i) begin
      if (!mgtreset_n_i) begin
         rx_state_q <= RxHunt;
         rx_idx_q   <= 3'd0;
         rx_crc_q   <= CrcInit;
         err_q      <= 16'd0;
         rxc_q      <= 16'd0;
         fa_valid_q <= 1'b0;
         fa_bs_q    <= 1'b0;
         fa_d_q     <= 16'd0;
      end else begin
         fa_valid_q <= 1'b0;
         fa_bs_q    <= 1'b0;
         fa_d_q     <= 16'd0;
         if (rx_state_q != RxHunt && is_sop) begin
            // An SOP inside a packet is an error but also the start of a new one.
            err_q      <= sat_inc(err_q);
            rx_state_q <= RxCapture;
            rx_idx_q   <= 3'd0;
            rx_crc_q   <= CrcInit;
         end else begin
            unique case (rx_state_q)
               RxHunt: begin
                  if (is_sop) begin
                     rx_state_q <= RxCapture;
                     rx_idx_q   <= 3'd0;
                     rx_crc_q   <= CrcInit;
                  end
               end
               RxCapture: begin
                  if (rx_charisk_i != DataK) begin
                     err_q      <= sat_inc(err_q);
                     rx_state_q <= RxHunt;
                  end else begin
                     fa_valid_q <= 1'b1;
                     fa_bs_q    <= (rx_idx_q == 3'd0);
                     fa_d_q     <= rx_data_i;
                     rx_crc_q   <= rx_crc_next;
                     if (rx_idx_q == PayloadLast) rx_state_q <= RxCheckCrc;
                     else                         rx_idx_q   <= rx_idx_q + 3'd1;
                  end
               end
               RxCheckCrc: begin
                  if (rx_charisk_i != DataK || rx_data_i != rx_crc_q) begin
                     err_q      <= sat_inc(err_q);
                     rx_state_q <= RxHunt;
                  end else begin
                     rx_state_q <= RxCheckEop;
                  end
               end
               RxCheckEop: begin
                  if (is_eop) rxc_q <= sat_inc(rxc_q);
                  else        err_q <= sat_inc(err_q);
                  rx_state_q <= RxHunt;
               end
            endcase
         end
      end
   end

   assign tx_data_o            = tx_data_q;
   assign tx_charisk_o         = tx_k_q;
   assign fai_fa_block_start_o = fa_bs_q;
   assign fai_fa_data_valid_o  = fa_valid_q;
   assign fai_fa_d_o           = fa_d_q;
   assign timeframe_start_o    = tf_start;
   assign timeframe_end_o      = tf_end;
   assign err_count_o          = err_q;
   assign rx_count_o           = rxc_q;
   assign test_done_o          = done_q;
   assign test_pass_o          = done_q && (err_q == 16'd0) && ({16'd0, rxc_q} >= TEST_DURATION);

endmodule

// File: tb/tb_fofb_cc_top_tester.sv
// Scoreboard bench for the FOFB CC tester: loopback, corrupted CRC, bench-driven RX, reset abort.
module tb_fofb_cc_top_tester;

   localparam int unsigned TD   = 3;
   localparam int unsigned TFP  = 10072;
   localparam int unsigned TFE  = 7500;
   localparam int unsigned TXI  = 6;
   localparam logic [15:0] NODE = 16'h0004;
   localparam logic [15:0] W_IDLE = 16'h50BC;
   localparam logic [15:0] W_SOP  = 16'h5CFB;
   localparam logic [15:0] W_EOP  = 16'hFDFE;
   localparam int DONE_CYC = 1 + (TD - 1) * TFP + TFE + 1;

   typedef logic [15:0] pkt_t [7];
   typedef struct packed {logic [15:0] d; logic bs;} exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] rx_data, tx_data, fa_d, err_cnt, rx_cnt;
   logic [1:0]  rx_k, tx_k;
   logic        fa_bs, fa_valid, tfs, tfe, done, pass;
   logic        rx_sel = 1'b0;
   logic        flip = 1'b0;
   logic [15:0] drv_d = 16'h50BC;
   logic [1:0]  drv_k = 2'b01;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   assign rx_data = rx_sel ? drv_d : (tx_data ^ {15'd0, flip});
   assign rx_k    = rx_sel ? drv_k : tx_k;

   fofb_cc_top_tester #(
      .TEST_DURATION (TD),
      .TF_PERIOD     (TFP),
      .TF_END        (TFE),
      .NODE_ID       (NODE),
      .TX_IDLE_NUM   (TXI)
   ) dut (
      .txusrclk2_i          (clk),
      .mgtreset_n_i         (rst_n),
      .rx_data_i            (rx_data),
      .rx_charisk_i         (rx_k),
      .tx_data_o            (tx_data),
      .tx_charisk_o         (tx_k),
      .fai_fa_block_start_o (fa_bs),
      .fai_fa_data_valid_o  (fa_valid),
      .fai_fa_d_o           (fa_d),
      .timeframe_start_o    (tfs),
      .timeframe_end_o      (tfe),
      .err_count_o          (err_cnt),
      .rx_count_o           (rx_cnt),
      .test_done_o          (done),
      .test_pass_o          (pass)
   );

   always #5 clk = ~clk;

   // Cycle index: 1 is the first cycle after reset release.
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (fa_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fai_word: got %h bs=%b, none expected (cycle %0d)", fa_d, fa_bs, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (fa_d !== mon_e.d || fa_bs !== mon_e.bs) begin
               n_fail++;
               $display("FAIL fai_word: got %h bs=%b expected %h bs=%b (cycle %0d)",
                        fa_d, fa_bs, mon_e.d, mon_e.bs, cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference CRC: the packet as one MSB-first bit stream through the 0x1021 divider.
   function automatic logic [15:0] crc_ref(input pkt_t p);
      logic [111:0] bits;
      logic [15:0]  c;
      logic         fb;
      bits = {p[0], p[1], p[2], p[3], p[4], p[5], p[6]};
      c = 16'hFFFF;
      for (int i = 111; i >= 0; i--) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic make_payload(input int unsigned fr, input int unsigned tf, output pkt_t p);
      logic [31:0] f, t;
      f = fr;
      t = tf;
      p[0] = NODE;
      p[1] = f[31:16];
      p[2] = f[15:0];
      p[3] = ~f[31:16];
      p[4] = ~f[15:0];
      p[5] = t[31:16];
      p[6] = t[15:0];
   endtask

   task automatic push_words(input pkt_t p, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{d: p[i], bs: (i == 0)});
   endtask

   task automatic push_frames(input int n);
      pkt_t p;
      for (int f = 0; f < n; f++) begin
         make_payload(f, f, p);
         push_words(p, 7);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", tx_data, W_IDLE);
      check("rst_tx_k", tx_k, 2'b01);
      check("rst_counts", {err_cnt, rx_cnt}, 32'd0);
      check("rst_flags", {fa_valid, fa_bs, fa_d, tfs, tfe, done, pass}, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("first_tf_start", tfs, 1'b1);
   endtask

   task automatic wait_sop(output int at);
      while (!(tx_data === W_SOP && tx_k === 2'b01) && cyc < 300) @(negedge clk);
      at = cyc;
   endtask

   task automatic wait_done();
      while (done !== 1'b1 && cyc < DONE_CYC + 200) @(negedge clk);
      check("done_cycle", cyc, DONE_CYC);
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] k);
      drv_d = d;
      drv_k = k;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input pkt_t p);
      send(W_SOP, 2'b01);
      for (int i = 0; i < 7; i++) send(p[i], 2'b00);
   endtask

   initial begin
      int   at, bad, kind, pos, exp_err, exp_rx;
      pkt_t p;

      // Reset state and clean loopback run.
      repeat (2) @(posedge clk);
      do_reset();
      push_frames(TD);
      release_reset();
      wait_sop(at);
      check("first_sop_cycle", at, 1 + TXI + 1);
      wait_done();
      check("lb_rx_count", rx_cnt, TD);
      check("lb_err_count", err_cnt, 0);
      check("lb_pass", pass, 1'b1);
      bad = 0;
      repeat (TFP - TFE + 200) begin
         @(negedge clk);
         if (tx_data !== W_IDLE || tx_k !== 2'b01) bad++;
      end
      check("tx_idle_after_done", bad, 0);
      check("done_sticky", done, 1'b1);

      // Loopback with bit 0 of the first CRC word flipped.
      do_reset();
      push_frames(TD);
      release_reset();
      wait_sop(at);
      repeat (8) @(posedge clk);
      #1 flip = 1'b1;
      @(posedge clk);
      #1 flip = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("crcflip_err", err_cnt, 1);
      check("crcflip_rx", rx_cnt, 0);
      wait_done();
      check("crcflip_rx_final", rx_cnt, TD - 1);
      check("crcflip_err_final", err_cnt, 1);
      check("crcflip_pass", pass, 1'b0);

      // Bench-driven receive: SOP injected at payload word 3, then clean and random packets.
      do_reset();
      rx_sel = 1'b1;
      drv_d  = W_IDLE;
      drv_k  = 2'b01;
      release_reset();
      for (int i = 0; i < 7; i++) p[i] = 16'($urandom);
      send(W_SOP, 2'b01);
      push_words(p, 3);
      for (int i = 0; i < 3; i++) send(p[i], 2'b00);
      for (int i = 0; i < 7; i++) p[i] = 16'($urandom);
      push_words(p, 7);
      send_pkt(p);
      send(crc_ref(p), 2'b00);
      send(W_EOP, 2'b11);
      send(W_IDLE, 2'b01);
      @(negedge clk);
      check("inject_err", err_cnt, 1);
      check("inject_rx", rx_cnt, 1);
      exp_err = 1;
      exp_rx  = 1;
      for (int n = 0; n < 12; n++) begin
         kind = $urandom_range(0, 3);
         for (int i = 0; i < 7; i++) p[i] = 16'($urandom);
         if (kind == 2) begin
            pos = $urandom_range(0, 6);
            push_words(p, pos);
            send(W_SOP, 2'b01);
            for (int i = 0; i < pos; i++) send(p[i], 2'b00);
            send(p[pos], 2'b10);
            exp_err++;
         end else begin
            push_words(p, 7);
            send_pkt(p);
            if (kind == 1) begin
               send(crc_ref(p) ^ (16'd1 << $urandom_range(0, 15)), 2'b00);
               exp_err++;
            end else begin
               send(crc_ref(p), 2'b00);
               if (kind == 3) begin
                  send(16'($urandom), 2'b00);
                  exp_err++;
               end else begin
                  send(W_EOP, 2'b11);
                  exp_rx++;
               end
            end
         end
         repeat ($urandom_range(1, 3)) send(W_IDLE, 2'b01);
      end
      @(negedge clk);
      check("random_err", err_cnt, exp_err);
      check("random_rx", rx_cnt, exp_rx);

      // Reset asserted while the third payload word is on the line.
      do_reset();
      rx_sel = 1'b0;
      release_reset();
      wait_sop(at);
      make_payload(0, 0, p);
      push_words(p, 2);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_tx_data", tx_data, W_IDLE);
      check("abort_tx_k", tx_k, 2'b01);
      check("abort_counts", {err_cnt, rx_cnt}, 32'd0);
      check("abort_fai_valid", fa_valid, 1'b0);
      check("abort_scoreboard", exp_q.size(), 0);
      push_words(p, 7);
      release_reset();
      wait_sop(at);
      check("restart_sop_cycle", at - 1, TXI + 1);
      repeat (12) @(negedge clk);
      check("restart_rx", rx_cnt, 1);
      check("restart_err", err_cnt, 0);
      check("restart_scoreboard", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
